// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite single-outstanding initiator.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP,
    DRAIN
  } axil_state_e;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  // States in which the per-phase watchdog runs.
  function automatic logic is_timed_phase(input axil_state_e s);
    return (s == WR_ADDR_DATA) || (s == WR_RESP) || (s == RD_ADDR) || (s == RD_DATA);
  endfunction

endpackage

// File: rtl/axil_timeout_ctr.sv
// Per-phase watchdog: expired is high in the TIMEOUT-th enabled cycle after a clear.
module axil_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  assign expired = enable && (r_count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/axil_master.sv
// Command/response front end driving one AXI4-Lite transaction at a time,
// with a per-phase timeout and draining of responses orphaned by a timeout.
module axil_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  axil_state_e r_state, w_next;

  logic                r_ready_en;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_resp;
  logic                r_timeout;
  logic                r_drain;
  logic                r_aw_done;
  logic                r_w_done;

  logic w_cmd_hs, w_aw_hs, w_w_hs, w_b_cap, w_r_cap;
  logic w_expired, w_to_event, w_pending;

  assign cmd_ready     = r_ready_en && (r_state == IDLE);
  assign m_axi_awvalid = (r_state == WR_ADDR_DATA) && !r_aw_done;
  assign m_axi_wvalid  = (r_state == WR_ADDR_DATA) && !r_w_done;
  assign m_axi_bready  = (r_state == WR_RESP) || ((r_state == DRAIN) && r_write);
  assign m_axi_arvalid = (r_state == RD_ADDR);
  assign m_axi_rready  = (r_state == RD_DATA) || ((r_state == DRAIN) && !r_write);
  assign m_axi_awaddr  = r_addr;
  assign m_axi_araddr  = r_addr;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign rsp_valid     = (r_state == RESP);
  assign rsp_rdata     = r_rdata;
  assign rsp_resp      = r_resp;
  assign rsp_timeout   = r_timeout;

  assign w_cmd_hs = cmd_valid && cmd_ready;
  assign w_aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_w_hs   = m_axi_wvalid && m_axi_wready;
  assign w_b_cap  = (r_state == WR_RESP) && m_axi_bvalid;
  assign w_r_cap  = (r_state == RD_DATA) && m_axi_rvalid;

  // Progress on the expiry cycle wins over the timeout.
  assign w_to_event = w_expired && (w_next == RESP) && !w_b_cap && !w_r_cap;

  // Once any handshake has gone out, the slave still owes a response.
  assign w_pending = (r_state == WR_RESP) || (r_state == RD_DATA) ||
                     ((r_state == WR_ADDR_DATA) &&
                      (r_aw_done || r_w_done || w_aw_hs || w_w_hs));

  axil_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clear  (w_next != r_state),
    .enable (is_timed_phase(r_state)),
    .expired(w_expired)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:         if (w_cmd_hs) w_next = cmd_write ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WR_RESP;
        else if (w_expired)                                  w_next = RESP;
      end
      WR_RESP:      if (m_axi_bvalid || w_expired)  w_next = RESP;
      RD_ADDR: begin
        if (m_axi_arready)  w_next = RD_DATA;
        else if (w_expired) w_next = RESP;
      end
      RD_DATA:      if (m_axi_rvalid || w_expired)  w_next = RESP;
      RESP:         if (rsp_ready) w_next = r_drain ? DRAIN : IDLE;
      DRAIN:        if (r_write ? m_axi_bvalid : m_axi_rvalid) w_next = IDLE;
      default:      w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready_en <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rdata    <= '0;
      r_resp     <= AXI_OKAY;
      r_timeout  <= 1'b0;
      r_drain    <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_cmd_hs) begin
        r_write   <= cmd_write;
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_rdata   <= '0;
        r_resp    <= AXI_OKAY;
        r_timeout <= 1'b0;
        r_drain   <= 1'b0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_b_cap) begin
        r_rdata <= '0;
        r_resp  <= m_axi_bresp;
      end
      if (w_r_cap) begin
        r_rdata <= m_axi_rdata;
        r_resp  <= m_axi_rresp;
      end
      if (w_to_event) begin
        r_timeout <= 1'b1;
        r_resp    <= AXI_SLVERR;
        r_rdata   <= '0;
        r_drain   <= w_pending;
      end
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// Directed vectors against a configurable-latency AXI4-Lite slave model.
module tb_axil_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  axil_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    int          rdy_dly;
    logic [31:0] e_rdata;
    logic [1:0]  e_resp;
    logic        e_to;
    int          e_lat;
    logic        e_drain;
    int          e_gap;
    int          e_arhi;
  } vec_t;

  int n_cmp = 0, n_fail = 0, cyc = 0;

  // slave model configuration and bookkeeping
  int          c_aw_dly, c_w_dly, c_ar_dly, c_b_dly, c_r_dly;
  logic [31:0] c_rdata;
  logic [1:0]  c_resp;
  bit          got_aw, got_w, got_ar, b_sent, r_sent, bv_hs, rv_hs, b_taken, r_taken;
  bit          aw_wait, w_wait, ar_wait, aw_drop, w_drop;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, aw_cyc, w_cyc, first_b, ar_hi;
  logic [3:0]  aw_prev, ar_prev, ws_prev, aw_seen, ar_seen, ws_seen;
  logic [31:0] wd_prev, wd_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic slave_clear();
    got_aw = 0; got_w = 0; got_ar = 0; b_sent = 0; r_sent = 0; bv_hs = 0; rv_hs = 0;
    b_taken = 0; r_taken = 0; aw_wait = 0; w_wait = 0; ar_wait = 0; aw_drop = 0; w_drop = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; aw_cyc = 0; w_cyc = 0;
    first_b = -1; ar_hi = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
  endtask

  // Runs at each falling edge; responses start the cycle after the last request handshake.
  task automatic slave_step();
    if (bv_hs) begin m_axi_bvalid = 0; bv_hs = 0; end
    if (got_aw && got_w && !b_sent) begin
      if (b_cnt == c_b_dly) begin m_axi_bvalid = 1; m_axi_bresp = c_resp; b_sent = 1; end
      b_cnt++;
    end
    if (m_axi_bvalid && m_axi_bready) begin bv_hs = 1; b_taken = 1; end
    if (rv_hs) begin m_axi_rvalid = 0; rv_hs = 0; end
    if (got_ar && !r_sent) begin
      if (r_cnt == c_r_dly) begin
        m_axi_rvalid = 1; m_axi_rdata = c_rdata; m_axi_rresp = c_resp; r_sent = 1;
      end
      r_cnt++;
    end
    if (m_axi_rvalid && m_axi_rready) begin rv_hs = 1; r_taken = 1; end

    if (resetn) begin
      if (aw_drop) chk("aw_drop", m_axi_awvalid, 0);
      if (w_drop)  chk("w_drop", m_axi_wvalid, 0);
      if (aw_wait && !rsp_valid) chk("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, aw_prev});
      if (w_wait && !rsp_valid)
        chk("w_hold", {m_axi_wvalid, m_axi_wdata, m_axi_wstrb}, {1'b1, wd_prev, ws_prev});
      if (ar_wait && !rsp_valid) chk("ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, ar_prev});
    end
    aw_drop = 0; w_drop = 0;
    if (m_axi_arvalid) ar_hi++;
    if (m_axi_bready && first_b < 0) first_b = cyc;

    m_axi_awready = 0;
    if (m_axi_awvalid && !got_aw) begin
      if (aw_cnt == c_aw_dly) begin
        m_axi_awready = 1; got_aw = 1; aw_cyc = cyc; aw_drop = 1; aw_seen = m_axi_awaddr;
      end
      aw_cnt++;
    end
    aw_wait = m_axi_awvalid && !m_axi_awready; aw_prev = m_axi_awaddr;
    m_axi_wready = 0;
    if (m_axi_wvalid && !got_w) begin
      if (w_cnt == c_w_dly) begin
        m_axi_wready = 1; got_w = 1; w_cyc = cyc; w_drop = 1;
        wd_seen = m_axi_wdata; ws_seen = m_axi_wstrb;
      end
      w_cnt++;
    end
    w_wait = m_axi_wvalid && !m_axi_wready; wd_prev = m_axi_wdata; ws_prev = m_axi_wstrb;
    m_axi_arready = 0;
    if (m_axi_arvalid && !got_ar) begin
      if (ar_cnt == c_ar_dly) begin m_axi_arready = 1; got_ar = 1; ar_seen = m_axi_araddr; end
      ar_cnt++;
    end
    ar_wait = m_axi_arvalid && !m_axi_arready; ar_prev = m_axi_araddr;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    slave_step();
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int n, lat;
    bit extra;
    slave_clear();
    c_aw_dly = v.aw_dly; c_w_dly = v.w_dly; c_ar_dly = v.ar_dly;
    c_b_dly = v.b_dly; c_r_dly = v.r_dly; c_rdata = v.s_rdata; c_resp = v.s_resp;
    tick();
    cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    cmd_valid = 1; rsp_ready = 0;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    chk({tag, "_accept"}, cmd_ready, 1);
    if (!cmd_ready) begin cmd_valid = 0; return; end
    tick();
    cmd_valid = 0;
    lat = 2;
    while (!rsp_valid && lat < 60) begin tick(); lat++; end
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    if (!rsp_valid) return;
    chk({tag, "_latency"}, lat, v.e_lat);
    chk({tag, "_payload"}, {rsp_rdata, rsp_resp, rsp_timeout}, {v.e_rdata, v.e_resp, v.e_to});
    if (v.e_arhi >= 0) chk({tag, "_ar_cycles"}, ar_hi, v.e_arhi);
    if (v.wr) begin
      chk({tag, "_aw_w_gap"}, aw_cyc - w_cyc, v.e_gap);
      chk({tag, "_wr_resp_entry"}, first_b, ((aw_cyc > w_cyc) ? aw_cyc : w_cyc) + 1);
      chk({tag, "_aw_w_data"}, {aw_seen, wd_seen, ws_seen}, {v.addr, v.wdata, v.wstrb});
    end else if (got_ar) begin
      chk({tag, "_ar_addr"}, ar_seen, v.addr);
    end
    for (int i = 0; i < v.rdy_dly; i++) begin
      tick();
      chk({tag, "_rsp_hold"}, {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout},
          {1'b1, v.e_rdata, v.e_resp, v.e_to});
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk({tag, "_rsp_done"}, rsp_valid, 0);
    chk({tag, "_post_state"}, cmd_ready, !v.e_drain);
    if (v.e_drain) begin
      n = 0; extra = 0;
      while (!(v.wr ? b_taken : r_taken) && n < 40) begin
        tick(); n++;
        if (rsp_valid) extra = 1;
      end
      chk({tag, "_drained"}, v.wr ? b_taken : r_taken, 1);
      tick(); if (rsp_valid) extra = 1;
      tick(); if (rsp_valid) extra = 1;
      chk({tag, "_no_second_rsp"}, extra, 0);
      chk({tag, "_idle"}, cmd_ready, 1);
    end
  endtask

  vec_t vt[12];

  initial begin
    int n;
    //          wr addr  wdata         strb aw w ar    b   r  s_rdata       rsp rdy e_rdata      e_rsp to lat dr gap arhi
    vt[0]  = '{1, 4'h0, 32'hA1B2C3D4, 4'hF, 0, 0, 0,    0,  0, 32'h0,        0,  0, 32'h0,        0, 0, 4,  0, 0,  -1};
    vt[1]  = '{0, 4'h4, 32'h0,        4'h0, 0, 0, 3,    0,  0, 32'h5A5A5A5A, 0,  0, 32'h5A5A5A5A, 0, 0, 7,  0, 0,  4};
    vt[2]  = '{1, 4'h8, 32'h12345678, 4'h3, 2, 0, 0,    0,  0, 32'h0,        2,  2, 32'h0,        2, 0, 6,  0, 2,  -1};
    vt[3]  = '{0, 4'hC, 32'h0,        4'h0, 0, 0, 1000, 0,  0, 32'hFFFFFFFF, 0,  0, 32'h0,        2, 1, 10, 0, 0,  8};
    vt[4]  = '{0, 4'h2, 32'h0,        4'h0, 0, 0, 0,    0, 12, 32'hDEADBEEF, 0,  0, 32'h0,        2, 1, 11, 1, 0,  1};
    vt[5]  = '{1, 4'h6, 32'h0F0F0F0F, 4'hF, 0, 0, 0,   12,  0, 32'h0,        0,  0, 32'h0,        2, 1, 11, 1, 0,  -1};
    vt[6]  = '{0, 4'hA, 32'h0,        4'h0, 0, 0, 0,    0,  0, 32'h0BADF00D, 3,  0, 32'h0BADF00D, 3, 0, 4,  0, 0,  1};
    vt[7]  = '{1, 4'hE, 32'h55AA55AA, 4'h5, 0, 0, 0,    0,  0, 32'h0,        1,  1, 32'h0,        1, 0, 4,  0, 0,  -1};
    vt[8]  = '{0, 4'h1, 32'h0,        4'h0, 0, 0, 0,    0,  7, 32'h13579BDF, 0,  0, 32'h13579BDF, 0, 0, 11, 0, 0,  1};
    vt[9]  = '{0, 4'h9, 32'h0,        4'h0, 0, 0, 0,    0,  8, 32'h2468ACE0, 0,  0, 32'h0,        2, 1, 11, 1, 0,  1};
    vt[10] = '{0, 4'h5, 32'h0,        4'h0, 0, 0, 0,    0,  5, 32'hFEDCBA98, 0,  1, 32'hFEDCBA98, 0, 0, 9,  0, 0,  1};
    vt[11] = '{1, 4'h3, 32'h89ABCDEF, 4'hC, 0, 3, 0,    0,  0, 32'h0,        0,  0, 32'h0,        0, 0, 7,  0, -3, -1};

    resetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    slave_clear();
    #3;
    chk("reset_outputs", {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
        m_axi_rready, rsp_valid, rsp_timeout, rsp_resp, m_axi_awaddr, m_axi_wdata}, 0);
    tick(); tick();
    resetn = 1;
    tick();
    chk("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 12; i++) run_txn(vt[i], $sformatf("v%0d", i));

    // reset while waiting for the write response
    slave_clear();
    c_aw_dly = 0; c_w_dly = 0; c_ar_dly = 0; c_b_dly = 20; c_r_dly = 0; c_resp = 0;
    tick();
    cmd_write = 1; cmd_addr = 4'hC; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'h9; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    tick();
    cmd_valid = 0;
    n = 0;
    while (!m_axi_bready && n < 20) begin tick(); n++; end
    chk("rst_in_wr_resp", m_axi_bready, 1);
    #2 resetn = 0;
    #1;
    chk("rst_async_ctrl", {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
        m_axi_rready, rsp_valid, rsp_timeout, rsp_resp, m_axi_awaddr, m_axi_araddr, m_axi_wstrb}, 0);
    chk("rst_async_data", {m_axi_wdata, rsp_rdata}, 0);
    slave_clear();
    tick(); tick();
    chk("rst_held_no_rsp", {cmd_ready, rsp_valid}, 0);
    resetn = 1;
    tick();
    chk("rst_release_ready", cmd_ready, 1);
    run_txn(vt[1], "post_rst_rd");
    run_txn(vt[0], "post_rst_wr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width; only 32 is supported.
REQ-003 SHALL have parameter TIMEOUT, default 255, the number of cycles to wait per phase before flagging a timeout.
REQ-004 SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  AXI BRESP or RRESP.
- rsp_timeout  out  1  the transaction timed out.
- m_axi_awaddr, m_axi_awvalid, m_axi_awready; m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_wready; m_axi_bresp, m_axi_bvalid, m_axi_bready; m_axi_araddr, m_axi_arvalid, m_axi_arready; m_axi_rdata, m_axi_rresp, m_axi_rvalid, m_axi_rready: the AXI4-Lite initiator channels, widths per AXI4-Lite.

Function
REQ-005 SHALL use the FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP, DRAIN.
REQ-006 SHALL assert cmd_ready only in IDLE; a cmd_valid && cmd_ready cycle latches the command and moves the FSM to WR_ADDR_DATA (write) or RD_ADDR (read).
REQ-007 SHALL assert m_axi_awvalid and m_axi_wvalid together in WR_ADDR_DATA, dropping each independently the cycle after its own ready handshake; the FSM moves to WR_RESP once both handshakes have occurred, including when both occur in the same cycle.
REQ-008 SHALL hold AXI address, data and strobe outputs stable while the corresponding valid is high; valid is never withdrawn before ready.
REQ-009 SHALL assert m_axi_bready only in WR_RESP and DRAIN; on bvalid it captures bresp and moves to RESP.
REQ-010 SHALL assert m_axi_arvalid in RD_ADDR, moving to RD_DATA on arready.
REQ-011 SHALL assert m_axi_rready only in RD_DATA and DRAIN; on rvalid it captures rdata and rresp and moves to RESP.
REQ-012 SHALL assert rsp_valid in RESP with its payload held stable until rsp_ready, then return to IDLE; rsp_valid high with rsp_ready high returns to IDLE in the same cycle.
REQ-013 SHALL give a minimum latency of 4 cycles from command accept to rsp_valid when the slave responds with zero wait states (ready high on entry, response one cycle later).
REQ-014 SHALL keep a phase counter that clears on every state entry and increments in WR_ADDR_DATA, WR_RESP, RD_ADDR and RD_DATA; reaching TIMEOUT moves the FSM to RESP with rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0.
REQ-015 SHALL, when a timeout occurs after an address or data handshake has already completed, complete the pending AXI response in DRAIN (ready held high) after the client response handshake, discarding that response; otherwise it returns directly to IDLE.
REQ-016 SHALL drive a write response with rsp_rdata=0 and rsp_timeout=0.

Reset
REQ-017 SHALL, on resetn low, immediately force the FSM to IDLE, all AXI valid and ready outputs to 0, rsp_valid=0, cmd_ready=0 during reset (1 in IDLE after release), and all data and address registers to 0.
REQ-018 SHALL abandon any in-flight transaction on a reset mid-transaction, with no response issued.

Structure
REQ-019 SHALL place the FSM state enum and the AXI response codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) in a shared package axil_pkg.
REQ-020 SHALL implement the timeout counter as the sub-module axil_timeout_ctr (inputs clear and enable, output expired).

Verification
REQ-021 SHALL cover a zero-wait write: command write, address 0x0, data 0xA1B2C3D4, strobes 0xF -> AW and W handshakes in the same cycle, then rsp_valid with resp 0 after 4 cycles.
REQ-022 SHALL cover a read where the slave delays arready by 3 cycles and returns rdata 0x5A5A5A5A -> arvalid held stable, then rsp_rdata=0x5A5A5A5A and resp=0.
REQ-023 SHALL cover split write handshakes: wready 2 cycles before awready -> wvalid drops first, and WR_RESP is entered only after the AW handshake.
REQ-024 SHALL cover a read timeout: TIMEOUT=8 with arready never asserted -> rsp_timeout=1 and resp=2 after 8 cycles, then a return to IDLE.
REQ-025 SHALL cover a drain case: rvalid withheld past the timeout, then asserted -> the late R beat is accepted in DRAIN and no second client response is issued.
REQ-026 SHALL cover reset asserted during WR_RESP -> all outputs return to their reset values asynchronously, and the next command completes normally.
